// File: rtl/sr_event_reader_pkg.sv
// Shared types and sizing helpers for the SR event reader.
package sr_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OFFER,
    ST_CLEAR
  } state_t;

  localparam int unsigned CNT_W = 16;

  function automatic int unsigned tmr_width(input int unsigned clr_max);
    return (clr_max < 2) ? 1 : $clog2(clr_max);
  endfunction

endpackage

// File: rtl/sr_event_arbiter.sv
// Picks one pending flag: lowest index first, or round-robin from i_ptr
// when SR_EVENT_READER_RR_EN is defined.
module sr_event_arbiter
  import sr_event_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_req,
`ifdef SR_EVENT_READER_RR_EN
  input  logic [IDX_W-1:0] i_ptr,
`endif
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
`ifdef SR_EVENT_READER_RR_EN
      w_pos = IDX_W'((32'(i_ptr) + i) % WIDTH);
`else
      w_pos = IDX_W'(i);
`endif
      if (!o_any && i_req[w_pos]) begin
        o_idx = w_pos;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_event_reader.sv
// Consumer for a bank of async SR flag latches: synchronize, select, offer,
// then pulse the latch reset. Round-robin selection via SR_EVENT_READER_RR_EN.
module sr_event_reader
  import sr_event_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned IDX_W   = $clog2(WIDTH),
  parameter int unsigned CLR_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             enable,
  input  logic             evt_ready,
  input  logic             stuck_clear,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx,
  output logic [WIDTH-1:0] clr_r,
  output logic [WIDTH-1:0] stuck,
  output logic [CNT_W-1:0] evt_count
);

  localparam int unsigned TMR_W = tmr_width(CLR_MAX);

  state_t             r_state, w_nxt_state;
  logic [WIDTH-1:0]   r_q_s1, r_q_sync;
  logic               r_valid, w_nxt_valid;
  logic [IDX_W-1:0]   r_idx, w_nxt_idx;
  logic [WIDTH-1:0]   r_clr, w_nxt_clr;
  logic [WIDTH-1:0]   r_stuck, w_nxt_stuck;
  logic [TMR_W-1:0]   r_timer, w_nxt_timer;
  logic [CNT_W-1:0]   r_count, w_nxt_count;
  logic [WIDTH-1:0]   w_cand, w_onehot;
  logic [IDX_W-1:0]   w_pick;
  logic               w_any;

  assign w_cand   = r_q_sync & ~r_stuck;
  assign w_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << r_idx;

`ifdef SR_EVENT_READER_RR_EN
  logic [IDX_W-1:0] r_ptr, w_nxt_ptr;

  sr_event_arbiter #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_arb (
    .i_req (w_cand),
    .i_ptr (r_ptr),
    .o_idx (w_pick),
    .o_any (w_any)
  );

  always_comb begin
    w_nxt_ptr = r_ptr;
    if (r_state == ST_OFFER && evt_ready)
      w_nxt_ptr = (r_idx == IDX_W'(WIDTH-1)) ? '0 : r_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_ptr <= '0;
    else       r_ptr <= w_nxt_ptr;
  end
`else
  sr_event_arbiter #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_arb (
    .i_req (w_cand),
    .o_idx (w_pick),
    .o_any (w_any)
  );
`endif

  // stuck_clear is applied first so a same-cycle timeout still sets its bit
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_valid = r_valid;
    w_nxt_idx   = r_idx;
    w_nxt_clr   = r_clr;
    w_nxt_timer = r_timer;
    w_nxt_count = r_count;
    w_nxt_stuck = stuck_clear ? '0 : r_stuck;
    case (r_state)
      ST_IDLE: begin
        if (enable && w_any) begin
          w_nxt_idx   = w_pick;
          w_nxt_valid = 1'b1;
          w_nxt_state = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          w_nxt_valid = 1'b0;
          w_nxt_count = r_count + 1'b1;
          w_nxt_clr   = w_onehot;
          w_nxt_timer = '0;
          w_nxt_state = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_nxt_timer = r_timer + 1'b1;
        if (!r_q_sync[r_idx]) begin
          w_nxt_clr   = '0;
          w_nxt_state = ST_IDLE;
        end else if (r_timer == TMR_W'(CLR_MAX-1)) begin
          w_nxt_clr          = '0;
          w_nxt_stuck[r_idx] = 1'b1;
          w_nxt_state        = ST_IDLE;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q_s1   <= '0;
      r_q_sync <= '0;
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_clr    <= '0;
      r_stuck  <= '0;
      r_timer  <= '0;
      r_count  <= '0;
    end else begin
      r_q_s1   <= q_in;
      r_q_sync <= r_q_s1;
      r_state  <= w_nxt_state;
      r_valid  <= w_nxt_valid;
      r_idx    <= w_nxt_idx;
      r_clr    <= w_nxt_clr;
      r_stuck  <= w_nxt_stuck;
      r_timer  <= w_nxt_timer;
      r_count  <= w_nxt_count;
    end
  end

  assign evt_valid = r_valid;
  assign evt_idx   = r_idx;
  assign clr_r     = r_clr;
  assign stuck     = r_stuck;
  assign evt_count = r_count;

endmodule

// File: tb/tb_sr_event_reader.sv
// Directed self-checking bench for sr_event_reader with a set-dominant
// SR latch model feeding q_in and cleared by clr_r.
module tb_sr_event_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        evt_ready = 1'b0;
  logic        stuck_clear = 1'b0;
  logic [7:0]  q_in = '0;
  logic [7:0]  s_vec = '0;
  logic        evt_valid;
  logic [2:0]  evt_idx;
  logic [7:0]  clr_r;
  logic [7:0]  stuck;
  logic [15:0] evt_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Latch bank: set dominates reset, state changes away from the DUT edge
  always @(negedge clk) q_in <= (q_in & ~clr_r) | s_vec;

  sr_event_reader #(.WIDTH(8), .CLR_MAX(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .q_in        (q_in),
    .enable      (enable),
    .evt_ready   (evt_ready),
    .stuck_clear (stuck_clear),
    .evt_valid   (evt_valid),
    .evt_idx     (evt_idx),
    .clr_r       (clr_r),
    .stuck       (stuck),
    .evt_count   (evt_count)
  );

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int unsigned maxc, input string tag);
    int unsigned n = 0;
    while (!evt_valid && n < maxc) begin
      step(1);
      n++;
    end
    chk(tag, 32'(evt_valid), 1);
  endtask

  task automatic wait_idle(input int unsigned maxc, input string tag);
    int unsigned n = 0;
    while ((evt_valid || clr_r != '0) && n < maxc) begin
      step(1);
      n++;
    end
    chk(tag, 32'(evt_valid || clr_r != '0), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_a, exp_b, exp_en;
`ifdef SR_EVENT_READER_RR_EN
    exp_a = 3'd7; exp_b = 3'd4; exp_en = 3'd4;
`else
    exp_a = 3'd4; exp_b = 3'd7; exp_en = 3'd0;
`endif

    // Reset values
    step(2);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_idx",   32'(evt_idx),   0);
    chk("rst_clr",   32'(clr_r),     0);
    chk("rst_stuck", 32'(stuck),     0);
    chk("rst_count", 32'(evt_count), 0);
    reset = 1'b0;
    enable = 1'b1;
    evt_ready = 1'b1;

    // Single flag: offer 3 edges after the rise, 3-cycle clear pulse
    s_vec = 8'h04;
    step(1); s_vec = '0;
    chk("t1_e0_valid", 32'(evt_valid), 0);
    step(1);
    chk("t1_e1_valid", 32'(evt_valid), 0);
    step(1);
    chk("t1_e2_valid", 32'(evt_valid), 1);
    chk("t1_e2_idx",   32'(evt_idx),   2);
    step(1);
    chk("t1_acc_valid", 32'(evt_valid), 0);
    chk("t1_acc_clr",   32'(clr_r),     32'h04);
    chk("t1_acc_count", 32'(evt_count), 1);
    step(1);
    chk("t1_clr2", 32'(clr_r), 32'h04);
    step(1);
    chk("t1_clr3", 32'(clr_r), 32'h04);
    step(1);
    chk("t1_clr_end", 32'(clr_r), 0);

    // Multiple flags, after having accepted index 5
    s_vec = 8'h20;
    step(1); s_vec = '0;
    wait_valid(8, "t2_pre_wait");
    chk("t2_pre_idx", 32'(evt_idx), 5);
    wait_idle(16, "t2_pre_idle");
    s_vec = 8'h90;
    step(1); s_vec = '0;
    wait_valid(8, "t2_a_wait");
    chk("t2_a_idx", 32'(evt_idx), 32'(exp_a));
    wait_idle(16, "t2_a_idle");
    wait_valid(8, "t2_b_wait");
    chk("t2_b_idx", 32'(evt_idx), 32'(exp_b));
    wait_idle(16, "t2_b_idle");
    chk("t2_count", 32'(evt_count), 4);

    // Backpressure: offer held stable, enable drop does not withdraw it
    evt_ready = 1'b0;
    s_vec = 8'h02;
    step(1); s_vec = '0;
    wait_valid(8, "t3_wait");
    for (int i = 0; i < 10; i++) begin
      if (i == 4) enable = 1'b0;
      step(1);
      chk($sformatf("t3_hold%0d_valid", i), 32'(evt_valid), 1);
      chk($sformatf("t3_hold%0d_idx", i),   32'(evt_idx),   1);
      chk($sformatf("t3_hold%0d_clr", i),   32'(clr_r),     0);
    end
    enable = 1'b1;
    evt_ready = 1'b1;
    step(1);
    chk("t3_acc_valid", 32'(evt_valid), 0);
    chk("t3_acc_clr",   32'(clr_r),     32'h02);
    chk("t3_acc_count", 32'(evt_count), 5);
    wait_idle(16, "t3_idle");

    // Stuck flag: set held on bit 3, clear pulse lasts exactly CLR_MAX
    s_vec = 8'h08;
    wait_valid(8, "t4_wait");
    chk("t4_idx", 32'(evt_idx), 3);
    step(1);
    chk("t4_clr0", 32'(clr_r), 32'h08);
    for (int k = 1; k < 8; k++) begin
      step(1);
      chk($sformatf("t4_clr%0d", k), 32'(clr_r), 32'h08);
    end
    step(1);
    chk("t4_to_clr",   32'(clr_r), 0);
    chk("t4_to_stuck", 32'(stuck), 32'h08);
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk($sformatf("t4_masked%0d", k), 32'(evt_valid), 0);
    end
    stuck_clear = 1'b1;
    step(1); stuck_clear = 1'b0;
    chk("t4_sc_stuck", 32'(stuck), 0);
    chk("t4_sc_valid", 32'(evt_valid), 0);
    step(1);
    chk("t4_reoffer_valid", 32'(evt_valid), 1);
    chk("t4_reoffer_idx",   32'(evt_idx),   3);

    // Reset in the second CLEAR cycle
    step(1);
    chk("t5_acc_clr", 32'(clr_r), 32'h08);
    step(1);
    chk("t5_clr2", 32'(clr_r), 32'h08);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t5_rst_valid", 32'(evt_valid), 0);
    chk("t5_rst_idx",   32'(evt_idx),   0);
    chk("t5_rst_clr",   32'(clr_r),     0);
    chk("t5_rst_stuck", 32'(stuck),     0);
    chk("t5_rst_count", 32'(evt_count), 0);
    step(1);
    chk("t5_r1_valid", 32'(evt_valid), 0);
    step(1);
    chk("t5_r2_valid", 32'(evt_valid), 0);
    step(1);
    chk("t5_r3_valid", 32'(evt_valid), 1);
    chk("t5_r3_idx",   32'(evt_idx),   3);
    s_vec = '0;
    wait_idle(16, "t5_idle");
    chk("t5_count", 32'(evt_count), 1);

    // Enable gating
    enable = 1'b0;
    s_vec = 8'hFF;
    step(1); s_vec = '0;
    step(5);
    chk("t6_dis_valid", 32'(evt_valid), 0);
    enable = 1'b1;
    step(1);
    chk("t6_en_valid", 32'(evt_valid), 1);
    chk("t6_en_idx",   32'(evt_idx),   32'(exp_en));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_event_reader.md
# sr_event_reader

Synchronous consumer for a bank of asynchronous set/reset flag latches. Samples the latched `q` vector through a two-flop synchronizer and selects one pending flag at a time. Presents the flag index on a valid/ready handshake, then drives a one-hot clear pulse back to the latch `r` inputs until the flag is seen low. Sits between the flag latch bank and the clocked control logic that services events.

## Interface
- `WIDTH`, 8: number of flags; also the width of `q_in`, `clr_r` and `stuck`.
- `IDX_W`, `$clog2(WIDTH)`: width of the event index.
- `CLR_MAX`, 8: maximum cycles spent in CLEAR before a flag is declared stuck; must be ≥ 4.

Ports (clock and reset first):
- `clk`, input, 1: single clock.
- `reset`, input, 1: synchronous, active-high reset.
- `q_in`, input, WIDTH: latched flags from the latch bank; asynchronous to `clk`.
- `enable`, input, 1: permits new selections.
- `evt_ready`, input, 1: consumer accepts the offered event.
- `stuck_clear`, input, 1: one-cycle pulse that clears all `stuck` bits.
- `evt_valid`, output, 1: an event is offered.
- `evt_idx`, output, IDX_W: index of the offered flag.
- `clr_r`, output, WIDTH: one-hot clear request, driven to the latch `r` inputs.
- `stuck`, output, WIDTH: sticky per-flag timeout indication.
- `evt_count`, output, 16: count of accepted events; wraps modulo 2^16.

## Operation
- Reset values: `evt_valid`=0, `evt_idx`=0, `clr_r`=0, `stuck`=0, `evt_count`=0, both synchronizer stages 0, FSM in IDLE, round-robin pointer 0.
- Synchronizer: `q_sync` = two flops of `q_in`. The FSM uses only `q_sync`.
- Candidate vector is `q_sync & ~stuck`.
- FSM states:
  - IDLE:
    - If `enable` is high and the candidate vector is nonzero, register the selected index into `evt_idx`, set `evt_valid`=1, and go to OFFER.
    - Otherwise stay in IDLE.
  - OFFER:
    - Hold `evt_valid` and `evt_idx` stable until `evt_valid & evt_ready` is sampled at a rising edge.
    - On that edge: `evt_valid`←0, `evt_count`+1, `clr_r`←one-hot(`evt_idx`), clear the timer, go to CLEAR.
    - Deasserting `enable` does not withdraw an offer.
  - CLEAR:
    - Timer increments each cycle.
    - If `q_sync[evt_idx]`==0: `clr_r`←0, go to IDLE.
    - Otherwise, if the timer reaches CLR_MAX−1: `clr_r`←0, `stuck[evt_idx]`←1, go to IDLE.
- Selection:
  - With `SR_EVENT_READER_RR_EN` defined, selection is round-robin (see Configuration).
  - Without it, selection is fixed priority, lowest index first.
- `stuck_clear` zeroes `stuck` on the next edge. If it coincides with a timeout, the timeout wins for that bit.
- A flag that re-rises while it is being cleared is handled normally: it is seen low once, then re-offered later.
- A `reset` at any point, including mid-OFFER or mid-CLEAR, returns all state to the reset values on the next edge; `clr_r` drops immediately after that edge.

## Timing
- Detection latency: a `q_in` bit rising before edge E0 appears in `q_sync` after E1. IDLE selects at E2, so `evt_valid` is high after E2 (3 edges).
- Handshake: accept on the edge where both signals are high. `clr_r` is high from that edge onward.
- Clear duration is 3 cycles nominal: the latch clears asynchronously, `q_sync` sees low 2 edges later, and the FSM exits on the following edge.
- The FSM spends at least 1 cycle in IDLE between events. Back-to-back throughput is therefore at most 1 event per 5 cycles with `evt_ready` tied high.
- Timeout path: `clr_r` stays high for exactly CLR_MAX cycles.

## Configuration
- `SR_EVENT_READER_RR_EN` defined:
  - Round-robin search starts at the index after the last accepted `evt_idx` and wraps from WIDTH−1 to 0.
  - The pointer updates on accept.
- Macro undefined:
  - Fixed lowest-index priority.
  - No pointer register.

## Structure
- Package `sr_event_pkg`:
  - FSM state enum (IDLE, OFFER, CLEAR).
  - Counter width constant (16).
  - Timer-width helper.
- Sub-module `sr_event_arbiter`:
  - Combinational pick of one index from the request vector plus the start pointer.
  - Outputs index and `any` flag.
  - Fixed-priority or round-robin behaviour is selected by the macro.
- Top level contains the synchronizer, FSM, timer, stuck register and counter.

## Test plan
- Single flag: `q_in`=8'h04 with `evt_ready`=1 → `evt_idx`=2 three edges after the rise; `clr_r`=8'h04 for 3 cycles; `evt_count`=1.
- Multiple flags: `q_in`=8'h90, fixed priority → event order 4 then 7. With `SR_EVENT_READER_RR_EN` and pointer after 5 → order 7 then 4.
- Backpressure: hold `evt_ready`=0 for 10 cycles → `evt_valid` and `evt_idx` stay stable and `clr_r` stays 0. Raising `evt_ready` → accept, then CLEAR.
- Stuck flag: latch `s` held high on bit 3 → `clr_r[3]` high for CLR_MAX=8 cycles, then `stuck`=8'h08 and bit 3 is never re-offered. A `stuck_clear` pulse → bit 3 is offered again.
- Reset mid-CLEAR: assert `reset` in the second CLEAR cycle → after that edge all outputs are 0 and the FSM is in IDLE. The pending flag is re-offered 3 edges after `reset` falls.
- `enable`=0 with `q_in`=8'hFF → no `evt_valid`. Setting `enable`=1 → offer on the next edge.
